// File: rtl/back_end_arbiter_native_if.sv
// ---------------------------------------------------------------------------
// back_end_arbiter_native_if
//
// Bundles the three native back-end channels that meet at the arbiter:
//   w_*   : cache write channel (write-through buffer drain)
//   r_*   : cache read channel (line refill, multi-beat burst)
//   mem_* : the single shared port toward memory / interconnect
//
// Modports:
//   master : arbiter view (owns mem_valid/addr/wdata/wstrb and both readies)
//   slave  : environment view (cache channels plus memory model)
//
// Parameters:
//   BE_ADDR_W  back-end address width
//   BE_DATA_W  back-end data width
//   BE_NBYTES  byte-strobe width (BE_DATA_W/8)
// ---------------------------------------------------------------------------
interface back_end_arbiter_native_if #(
  parameter int BE_ADDR_W = 32,
  parameter int BE_DATA_W = 32,
  parameter int BE_NBYTES = BE_DATA_W / 8
);

  // Write channel
  logic                 w_valid;
  logic [BE_ADDR_W-1:0] w_addr;
  logic [BE_DATA_W-1:0] w_wdata;
  logic [BE_NBYTES-1:0] w_wstrb;
  logic                 w_ready;

  // Read channel
  logic                 r_valid;
  logic [BE_ADDR_W-1:0] r_addr;
  logic                 r_ready;
  logic [BE_DATA_W-1:0] r_rdata;

  // Shared memory port
  logic                 mem_valid;
  logic [BE_ADDR_W-1:0] mem_addr;
  logic [BE_DATA_W-1:0] mem_wdata;
  logic [BE_NBYTES-1:0] mem_wstrb;
  logic                 mem_ready;
  logic [BE_DATA_W-1:0] mem_rdata;

  modport master (
    input  w_valid, w_addr, w_wdata, w_wstrb,
    input  r_valid, r_addr,
    input  mem_ready, mem_rdata,
    output w_ready, r_ready, r_rdata,
    output mem_valid, mem_addr, mem_wdata, mem_wstrb
  );

  modport slave (
    output w_valid, w_addr, w_wdata, w_wstrb,
    output r_valid, r_addr,
    output mem_ready, mem_rdata,
    input  w_ready, r_ready, r_rdata,
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb
  );

endinterface

// File: rtl/back_end_arbiter_native.sv
// ---------------------------------------------------------------------------
// back_end_arbiter_native
//
// Shares one native back-end memory port between the cache write channel and
// the read (refill) channel. A grant is taken from IDLE, held for as long as
// the owning channel keeps its valid high (so a whole refill burst stays
// atomic) and released only when that valid is seen low at a clock edge.
// Ties in IDLE are broken round-robin against the last released owner.
//
// Ports:
//   clk    clock
//   reset  asynchronous, active-low reset
//   bus    back_end_arbiter_native_if.master (w_*, r_*, mem_* signals)
//   busy   high while either channel holds the grant
// ---------------------------------------------------------------------------
module back_end_arbiter_native (
  input  logic                               clk,
  input  logic                               reset,
  back_end_arbiter_native_if.master          bus,
  output logic                               busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_W = 2'd1;
  localparam logic [1:0] GNT_R = 2'd2;

  logic [1:0] state_q, state_d;
  // High when the write channel was the most recent owner to release.
  // Reset value 0 means "last grant was read", so write wins the first tie.
  logic       last_w_q, last_w_d;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable assigned here gets a default first so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    state_d  = state_q;
    last_w_d = last_w_q;
    unique case (state_q)
      IDLE: begin
        if (bus.w_valid && bus.r_valid) begin
          state_d = last_w_q ? GNT_R : GNT_W;
        end else if (bus.w_valid) begin
          state_d = GNT_W;
        end else if (bus.r_valid) begin
          state_d = GNT_R;
        end
      end
      GNT_W: begin
        if (!bus.w_valid) begin
          state_d  = IDLE;
          last_w_d = 1'b1;
        end
      end
      GNT_R: begin
        if (!bus.r_valid) begin
          state_d  = IDLE;
          last_w_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      last_w_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_w_q <= last_w_d;
    end
  end

  // -------------------------------------------------------------------------
  // Output routing: purely a function of the registered grant, so an
  // asynchronous reset silences the memory port in the same instant.
  // -------------------------------------------------------------------------
  always_comb begin
    bus.mem_valid = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    bus.w_ready   = 1'b0;
    bus.r_ready   = 1'b0;
    unique case (state_q)
      GNT_W: begin
        bus.mem_valid = bus.w_valid;
        bus.mem_addr  = bus.w_addr;
        bus.mem_wdata = bus.w_wdata;
        bus.mem_wstrb = bus.w_wstrb;
        bus.w_ready   = bus.mem_ready;
      end
      GNT_R: begin
        // All-zero strobe marks the access as a read.
        bus.mem_valid = bus.r_valid;
        bus.mem_addr  = bus.r_addr;
        bus.r_ready   = bus.mem_ready;
      end
      default: ;
    endcase
  end

  // Read data is a straight wire; r_ready qualifies it.
  assign bus.r_rdata = bus.mem_rdata;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_back_end_arbiter_native.sv
// ---------------------------------------------------------------------------
// tb_back_end_arbiter_native
//
// Directed scenarios with literal expectations followed by a randomized run.
// A reference model tracks only "who owns the port" and "who released last";
// the compare process derives every output from that each negative edge.
// ---------------------------------------------------------------------------
module tb_back_end_arbiter_native;

  logic clk;
  logic reset;
  logic busy;

  int checks = 0;
  int errors = 0;

  back_end_arbiter_native_if #(.BE_ADDR_W(32), .BE_DATA_W(32)) bus ();

  back_end_arbiter_native dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------------
  // Reference model: owner of the port and last releaser.
  // ------------------------------------------------------------------------
  typedef enum {NONE, OWN_W, OWN_R} owner_t;
  owner_t owner;
  bit     last_was_w;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner      <= NONE;
      last_was_w <= 1'b0;
    end else begin
      if (owner == NONE) begin
        // Round-robin: on a tie prefer whoever did not release last.
        if (bus.w_valid && bus.r_valid) owner <= last_was_w ? OWN_R : OWN_W;
        else if (bus.w_valid)           owner <= OWN_W;
        else if (bus.r_valid)           owner <= OWN_R;
      end else if (owner == OWN_W && !bus.w_valid) begin
        owner      <= NONE;
        last_was_w <= 1'b1;
      end else if (owner == OWN_R && !bus.r_valid) begin
        owner      <= NONE;
        last_was_w <= 1'b0;
      end
    end
  end

  // Compare process: every output against the model, every cycle.
  always @(negedge clk) begin
    logic        e_valid, e_wr, e_rr;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wstrb;
    e_valid = 1'b0; e_wr = 1'b0; e_rr = 1'b0;
    e_addr  = '0;   e_wdata = '0; e_wstrb = '0;
    if (owner == OWN_W) begin
      e_valid = bus.w_valid; e_addr = bus.w_addr;
      e_wdata = bus.w_wdata; e_wstrb = bus.w_wstrb;
      e_wr    = bus.mem_ready;
    end else if (owner == OWN_R) begin
      e_valid = bus.r_valid; e_addr = bus.r_addr;
      e_rr    = bus.mem_ready;
    end
    check("cmp_busy",      busy,          (owner != NONE));
    check("cmp_mem_valid", bus.mem_valid, e_valid);
    check("cmp_mem_addr",  bus.mem_addr,  e_addr);
    check("cmp_mem_wdata", bus.mem_wdata, e_wdata);
    check("cmp_mem_wstrb", bus.mem_wstrb, e_wstrb);
    check("cmp_w_ready",   bus.w_ready,   e_wr);
    check("cmp_r_ready",   bus.r_ready,   e_rr);
    check("cmp_r_rdata",   bus.r_rdata,   bus.mem_rdata);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.w_valid = 1'b0; bus.w_addr = '0; bus.w_wdata = '0; bus.w_wstrb = '0;
    bus.r_valid = 1'b0; bus.r_addr = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] rd;
    reset = 1'b0;
    clear_inputs();
    tick();
    tick();
    reset = 1'b1;

    // Reset state
    check("reset_busy",      busy, 1'b0);
    check("reset_mem_valid", bus.mem_valid, 1'b0);

    // Single write, memory ready after 2 cycles
    bus.w_valid = 1'b1; bus.w_addr = 32'h100;
    bus.w_wdata = 32'hDEADBEEF; bus.w_wstrb = 4'hF;
    #1 check("wr_latency_idle", bus.mem_valid, 1'b0);
    tick();
    check("wr_mem_valid", bus.mem_valid, 1'b1);
    check("wr_mem_addr",  bus.mem_addr,  32'h100);
    check("wr_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    check("wr_mem_wstrb", bus.mem_wstrb, 4'hF);
    check("wr_ready_lo",  bus.w_ready,   1'b0);
    tick();
    bus.mem_ready = 1'b1;
    #1 check("wr_ready_pulse", bus.w_ready, 1'b1);
    tick();
    bus.mem_ready = 1'b0; bus.w_valid = 1'b0;
    tick();
    check("wr_release_idle", busy, 1'b0);

    // Read burst of 4 beats, write arrives at beat 2
    bus.r_valid = 1'b1; bus.r_addr = 32'h200;
    tick();
    check("rd_granted", busy, 1'b1);
    for (int i = 0; i < 4; i++) begin
      rd = $urandom;
      bus.r_addr = 32'h200 + 32'(4 * i);
      bus.mem_ready = 1'b1; bus.mem_rdata = rd;
      if (i == 2) begin
        bus.w_valid = 1'b1; bus.w_addr = 32'h300;
        bus.w_wdata = 32'h12345678; bus.w_wstrb = 4'h3;
      end
      #1;
      check("rd_r_ready", bus.r_ready,   1'b1);
      check("rd_r_rdata", bus.r_rdata,   rd);
      check("rd_addr",    bus.mem_addr,  32'h200 + 32'(4 * i));
      check("rd_wstrb",   bus.mem_wstrb, 4'h0);
      check("rd_w_ready", bus.w_ready,   1'b0);
      tick();
    end
    bus.r_valid = 1'b0; bus.mem_ready = 1'b0;
    tick();
    check("rd_release_idle", busy, 1'b0);
    check("rd_idle_no_mem",  bus.mem_valid, 1'b0);
    tick();
    check("wr_after_rd_addr",  bus.mem_addr,  32'h300);
    check("wr_after_rd_wstrb", bus.mem_wstrb, 4'h3);
    bus.w_valid = 1'b0;
    tick();

    // Reset asserted during GNT_R beat 2
    bus.r_valid = 1'b1; bus.r_addr = 32'h400;
    tick();
    tick();
    bus.r_addr = 32'h404; bus.mem_ready = 1'b1;
    #1 check("rst_pre_r_ready", bus.r_ready, 1'b1);
    reset = 1'b0;
    #1;
    check("rst_mem_valid", bus.mem_valid, 1'b0);
    check("rst_r_ready",   bus.r_ready,   1'b0);
    check("rst_busy",      busy,          1'b0);
    bus.r_valid = 1'b0; bus.mem_ready = 1'b0;
    bus.w_valid = 1'b1; bus.w_addr = 32'h500; bus.w_wstrb = 4'hC;
    tick();
    reset = 1'b1;
    tick();
    check("rst_wr_granted", bus.mem_valid, 1'b1);
    check("rst_wr_addr",    bus.mem_addr,  32'h500);
    bus.w_valid = 1'b0;
    tick();

    // Tie after reset: write first, then read, then a second tie goes to read
    do_reset();
    bus.w_valid = 1'b1; bus.w_addr = 32'h600; bus.w_wstrb = 4'h1;
    bus.r_valid = 1'b1; bus.r_addr = 32'h700;
    tick();
    check("tie1_write_addr",  bus.mem_addr,  32'h600);
    check("tie1_write_wstrb", bus.mem_wstrb, 4'h1);
    check("tie1_r_ready",     bus.r_ready,   1'b0);
    bus.w_valid = 1'b0;
    tick();
    check("tie1_turnaround", busy, 1'b0);
    bus.w_valid = 1'b1;
    tick();
    check("tie2_read_addr",  bus.mem_addr,  32'h700);
    check("tie2_read_wstrb", bus.mem_wstrb, 4'h0);
    bus.r_valid = 1'b0; bus.w_valid = 1'b0;
    tick();

    // Spurious mem_ready in IDLE
    bus.mem_ready = 1'b1;
    #1;
    check("spur_w_ready", bus.w_ready, 1'b0);
    check("spur_r_ready", bus.r_ready, 1'b0);
    tick();
    check("spur_busy", busy, 1'b0);
    bus.mem_ready = 1'b0;

    // Randomized run
    for (int c = 0; c < 3000; c++) begin
      if (bus.w_valid) bus.w_valid = ($urandom_range(99) < 85);
      else             bus.w_valid = ($urandom_range(99) < 30);
      if (bus.r_valid) bus.r_valid = ($urandom_range(99) < 85);
      else             bus.r_valid = ($urandom_range(99) < 30);
      bus.w_addr    = $urandom;
      bus.w_wdata   = $urandom;
      bus.w_wstrb   = 4'($urandom);
      bus.r_addr    = $urandom;
      bus.mem_ready = 1'($urandom);
      bus.mem_rdata = $urandom;
      if (!reset) reset = 1'b1;
      else if ($urandom_range(299) == 0) reset = 1'b0;
      tick();
    end

    reset = 1'b1;
    clear_inputs();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/back_end_arbiter_native.md
Name: back_end_arbiter_native

Overview:
- Shares one native back-end memory port between the cache write channel (write-through buffer drain) and the read channel (line refill).
- Grants the port to one requester at a time and holds the grant for the whole transaction or burst.
- Releases the grant only when the granted requester drops valid.
- Sits between the cache back-end channels and the external memory/interconnect.

Parameters:
- BE_ADDR_W, 32, back-end address width
- BE_DATA_W, 32, back-end data width
- BE_NBYTES, BE_DATA_W/8, byte-strobe width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (reset==0 resets the block)
- w_valid  in  1  write-channel request
- w_addr  in  BE_ADDR_W  write address
- w_wdata  in  BE_DATA_W  write data
- w_wstrb  in  BE_NBYTES  write byte enables
- w_ready  out  1  write accepted (beat done)
- r_valid  in  1  read-channel request (held for full line burst)
- r_addr  in  BE_ADDR_W  read address (changes per beat)
- r_ready  out  1  read beat done
- r_rdata  out  BE_DATA_W  read data
- mem_valid  out  1  to memory
- mem_addr  out  BE_ADDR_W  to memory
- mem_wdata  out  BE_DATA_W  to memory
- mem_wstrb  out  BE_NBYTES  to memory; all-zero means read
- mem_ready  in  1  from memory
- mem_rdata  in  BE_DATA_W  from memory
- busy  out  1  a grant is active

Behaviour:
- FSM, registered, 2-bit:
  - IDLE: no grant.
  - GNT_W: write channel owns the port.
  - GNT_R: read channel owns the port.
- Reset (reset==0, asynchronous):
  - state=IDLE, last_grant=R (so the write channel wins the first tie).
  - All outputs 0; r_rdata follows mem_rdata unconditionally.
- IDLE transitions:
  - Only w_valid: go to GNT_W.
  - Only r_valid: go to GNT_R.
  - Both valid: grant the channel that is NOT last_grant (round-robin).
  - Neither valid: stay in IDLE.
  - Grant latency: 1 cycle from request to mem_valid; no memory traffic in IDLE.
- GNT_W (combinational outputs):
  - mem_valid=w_valid, mem_addr=w_addr, mem_wdata=w_wdata, mem_wstrb=w_wstrb.
  - w_ready=mem_ready; r_ready=0.
- GNT_R (combinational outputs):
  - mem_valid=r_valid, mem_addr=r_addr, mem_wdata=0, mem_wstrb=0.
  - r_ready=mem_ready; w_ready=0.
- Release:
  - In GNT_x, sampling the granted valid=0 at a clock edge returns the FSM to IDLE and sets last_grant=x.
  - A multi-beat burst whose valid stays high across beats keeps the grant; the grant is never preempted.
  - A requester that drops valid for one cycle mid-burst loses the grant.
- Turnaround: minimum 1 IDLE cycle between grants.
  - Back-to-back requests from both channels alternate W, R, W, ...
- Non-granted requester:
  - Its ready is held 0 and its inputs are ignored.
  - It must keep valid high until granted; the arbiter imposes no timeout.
- Simultaneous events:
  - Granted valid falling in the same cycle the other valid rises: release first, then the other is granted from IDLE next cycle.
  - mem_ready asserted with mem_valid=0 (IDLE or after a drop) is ignored; no ready is routed in IDLE.
- Outputs:
  - busy = (state != IDLE).
  - mem_addr, mem_wdata and mem_wstrb are 0 in IDLE.
- Reset mid-burst: immediate return to IDLE with mem_valid=0. The outstanding beat is abandoned and the requesters restart.

Test Plan:
- Single write: w_valid=1, w_addr=0x100, w_wdata=0xDEADBEEF, w_wstrb=0xF; memory ready after 2 cycles -> mem_valid rises 1 cycle after w_valid; mem_addr=0x100, mem_wstrb=0xF; w_ready pulses once; FSM returns to IDLE after w_valid drops.
- Read burst of 4 beats: r_addr 0x200, 0x204, 0x208, 0x20C with mem_ready every cycle -> mem_wstrb=0; r_ready pulses 4 times; r_rdata equals mem_rdata on each pulse; grant held across all 4 beats.
- Simultaneous w_valid and r_valid after reset -> write granted first; read granted after the write releases plus 1 IDLE cycle; a second tie is granted to read.
- w_valid rises mid read burst (beat 2 of 4) -> w_ready stays 0; mem_addr tracks r_addr until the burst ends; write granted 1 cycle after r_valid drops.
- Assert reset=0 during GNT_R beat 2 -> mem_valid, r_ready and busy go 0 asynchronously; state=IDLE; after reset=1 with only w_valid high, write granted next cycle.
- Spurious mem_ready=1 in IDLE -> w_ready=r_ready=0, no state change.
